// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table response checker.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the checker FSM state enum, the vector-count helper and the expected
// truth tables of the team's common 3-input reference circuits.
package tt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } tt_state_e;

    // Number of distinct input vectors for an n_in-input circuit.
    function automatic int tt_n_vec(input int n_in);
        return 1 << n_in;
    endfunction

    // Bit i is the expected Z for input vector i. Bit 2 of i is input A.
    localparam logic [7:0] TT_EXP_ZERO = 8'b0000_0000;
    localparam logic [7:0] TT_EXP_MAJ3 = 8'b1110_1000;
    localparam logic [7:0] TT_EXP_AND3 = 8'b1000_0000;
    localparam logic [7:0] TT_EXP_OR3  = 8'b1111_1110;
    localparam logic [7:0] TT_EXP_XOR3 = 8'b1001_0110;

endpackage

// File: rtl/tt_cov_table.sv
// Observed/covered truth-table storage with first-sight vs repeat classification.
// Latency: table updates are visible one cycle after the write edge; flags are combinational.
// Backpressure: none, accepts one write per cycle.
//
// Ports:
//   clk, rst        clock and async active-high reset
//   clear_i         clears both tables (has priority over wr_i)
//   wr_i, vec_i,z_i accepted sample: vector index and observed Z
//   observed_o      first Z seen per vector (meaningful only where covered)
//   covered_o       vector-seen mask
//   first_sight_o   current write hits a not-yet-covered vector
//   conflict_o      current write repeats a vector with a different Z
//   last_new_o      current write covers the final uncovered vector
module tt_cov_table
    import tt_pkg::*;
#(
    parameter  int N_IN  = 3,
    localparam int N_VEC = tt_n_vec(N_IN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             wr_i,
    input  logic [N_IN-1:0]  vec_i,
    input  logic             z_i,
    output logic [N_VEC-1:0] observed_o,
    output logic [N_VEC-1:0] covered_o,
    output logic             first_sight_o,
    output logic             conflict_o,
    output logic             last_new_o
);

    logic [N_VEC-1:0] observed_q, observed_d;
    logic [N_VEC-1:0] covered_q,  covered_d;
    logic [N_VEC-1:0] vec_onehot;

    always_comb begin
        vec_onehot         = '0;
        vec_onehot[vec_i]  = 1'b1;

        first_sight_o = wr_i && !covered_q[vec_i];
        conflict_o    = wr_i && covered_q[vec_i] && (observed_q[vec_i] != z_i);
        // Completion is about the set of vectors, not the sample count, so the
        // final new vector is the one that fills the last hole in the mask.
        last_new_o    = first_sight_o && ((covered_q | vec_onehot) == {N_VEC{1'b1}});

        observed_d = observed_q;
        covered_d  = covered_q;
        if (clear_i) begin
            observed_d = '0;
            covered_d  = '0;
        end else if (first_sight_o) begin
            // Repeats never overwrite: the first Z is the reference for consistency.
            observed_d[vec_i] = z_i;
            covered_d         = covered_q | vec_onehot;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            observed_q <= '0;
            covered_q  <= '0;
        end else begin
            observed_q <= observed_d;
            covered_q  <= covered_d;
        end
    end

    assign observed_o = observed_q;
    assign covered_o  = covered_q;

endmodule

// File: rtl/tt_response_checker.sv
// Checks a DUT's single-bit response over an exhaustive truth-table sweep and gives a done/pass verdict.
// Latency: a sample at edge k is reflected on all (registered) outputs after edge k.
// Backpressure: none; one sample per cycle, samples outside a run are ignored.
//
// Ports:
//   clk, rst                    clock and async active-high reset
//   start_i                     clear all state and (re)start a run; beats valid_i
//   valid_i, vec_i, z_i         sample strobe, applied vector (MSB = A), DUT output
//   observed_o, covered_o       observed truth table and vector-seen mask
//   mismatch_cnt_o              saturating count of samples differing from EXPECTED
//   inconsistent_o              sticky: a repeated vector returned a different Z
//   busy_o, done_o, pass_o      run in progress / all vectors seen / clean verdict
// Optional (macro TT_CHECKER_FIRST_FAIL_EN):
//   first_fail_vld_o, first_fail_vec_o   first mismatching vector of the run
module tt_response_checker
    import tt_pkg::*;
#(
    parameter int                        N_IN     = 3,
    parameter logic [(1 << N_IN)-1:0]    EXPECTED = '0,
    parameter int                        CW       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     valid_i,
    input  logic [N_IN-1:0]          vec_i,
    input  logic                     z_i,
    output logic [(1 << N_IN)-1:0]   observed_o,
    output logic [(1 << N_IN)-1:0]   covered_o,
    output logic [CW-1:0]            mismatch_cnt_o,
    output logic                     inconsistent_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     pass_o
`ifdef TT_CHECKER_FIRST_FAIL_EN
    ,
    output logic                     first_fail_vld_o,
    output logic [N_IN-1:0]          first_fail_vec_o
`endif
);

    tt_state_e         state_q, state_d;
    logic [CW-1:0]     mismatch_cnt_q, mismatch_cnt_d;
    logic              inconsistent_q, inconsistent_d;
    logic              pass_q, pass_d;
`ifdef TT_CHECKER_FIRST_FAIL_EN
    logic              first_fail_vld_q, first_fail_vld_d;
    logic [N_IN-1:0]   first_fail_vec_q, first_fail_vec_d;
`endif

    logic sample_acc;
    logic sample_mismatch;
    logic first_sight;
    logic conflict;
    logic last_new;

    // start_i wins over a coincident sample, which is dropped.
    assign sample_acc      = valid_i && !start_i && (state_q == ST_CHECK);
    assign sample_mismatch = (z_i != EXPECTED[vec_i]);

    tt_cov_table #(
        .N_IN (N_IN)
    ) u_cov_table (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (start_i),
        .wr_i          (sample_acc),
        .vec_i         (vec_i),
        .z_i           (z_i),
        .observed_o    (observed_o),
        .covered_o     (covered_o),
        .first_sight_o (first_sight),
        .conflict_o    (conflict),
        .last_new_o    (last_new)
    );

    always_comb begin
        state_d        = state_q;
        mismatch_cnt_d = mismatch_cnt_q;
        inconsistent_d = inconsistent_q;
`ifdef TT_CHECKER_FIRST_FAIL_EN
        first_fail_vld_d = first_fail_vld_q;
        first_fail_vec_d = first_fail_vec_q;
`endif

        unique case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_CHECK;
            ST_CHECK: if (!start_i && last_new) state_d = ST_DONE;
            ST_DONE:  if (start_i) state_d = ST_CHECK;
            default:  state_d = ST_IDLE;
        endcase

        if (start_i) begin
            mismatch_cnt_d = '0;
            inconsistent_d = 1'b0;
`ifdef TT_CHECKER_FIRST_FAIL_EN
            first_fail_vld_d = 1'b0;
            first_fail_vec_d = '0;
`endif
        end else if (sample_acc) begin
            if (sample_mismatch && (mismatch_cnt_q != {CW{1'b1}})) begin
                mismatch_cnt_d = mismatch_cnt_q + CW'(1);
            end
            if (conflict) begin
                inconsistent_d = 1'b1;
            end
`ifdef TT_CHECKER_FIRST_FAIL_EN
            if (sample_mismatch && !first_fail_vld_q) begin
                first_fail_vld_d = 1'b1;
                first_fail_vec_d = vec_i;
            end
`endif
        end

        // Verdict is registered alongside the state so it appears with done_o.
        pass_d = (state_d == ST_DONE) && (mismatch_cnt_d == '0) && !inconsistent_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            mismatch_cnt_q <= '0;
            inconsistent_q <= 1'b0;
            pass_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            mismatch_cnt_q <= mismatch_cnt_d;
            inconsistent_q <= inconsistent_d;
            pass_q         <= pass_d;
        end
    end

`ifdef TT_CHECKER_FIRST_FAIL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_fail_vld_q <= 1'b0;
            first_fail_vec_q <= '0;
        end else begin
            first_fail_vld_q <= first_fail_vld_d;
            first_fail_vec_q <= first_fail_vec_d;
        end
    end

    assign first_fail_vld_o = first_fail_vld_q;
    assign first_fail_vec_o = first_fail_vec_q;
`endif

    assign mismatch_cnt_o = mismatch_cnt_q;
    assign inconsistent_o = inconsistent_q;
    assign busy_o         = (state_q == ST_CHECK);
    assign done_o         = (state_q == ST_DONE);
    assign pass_o         = pass_q;

endmodule

// File: tb/tb_tt_response_checker.sv
// Randomized + directed bench for tt_response_checker with a queue-based scoreboard.
// Stimulus pushes the expected post-edge output snapshot; a negedge monitor pops and compares.
// A second instance with CW=2 shares the inputs to exercise counter saturation.
module tb_tt_response_checker;

    localparam logic [7:0] EXP_TT = 8'b1110_1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic       valid_i = 1'b0;
    logic [2:0] vec_i = '0;
    logic       z_i = 1'b0;

    logic [7:0] observed_o, covered_o, mismatch_cnt_o;
    logic       inconsistent_o, busy_o, done_o, pass_o;
    logic [7:0] s_observed_o, s_covered_o;
    logic [1:0] s_mismatch_cnt_o;
    logic       s_inconsistent_o, s_busy_o, s_done_o, s_pass_o;
`ifdef TT_CHECKER_FIRST_FAIL_EN
    logic       first_fail_vld_o, s_first_fail_vld_o;
    logic [2:0] first_fail_vec_o, s_first_fail_vec_o;
`endif

    always #5 clk = ~clk;

    tt_response_checker #(.N_IN(3), .EXPECTED(EXP_TT), .CW(8)) u_dut (
        .clk(clk), .rst(rst), .start_i(start_i), .valid_i(valid_i), .vec_i(vec_i), .z_i(z_i),
        .observed_o(observed_o), .covered_o(covered_o), .mismatch_cnt_o(mismatch_cnt_o),
        .inconsistent_o(inconsistent_o), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o)
`ifdef TT_CHECKER_FIRST_FAIL_EN
        , .first_fail_vld_o(first_fail_vld_o), .first_fail_vec_o(first_fail_vec_o)
`endif
    );

    tt_response_checker #(.N_IN(3), .EXPECTED(EXP_TT), .CW(2)) u_sat (
        .clk(clk), .rst(rst), .start_i(start_i), .valid_i(valid_i), .vec_i(vec_i), .z_i(z_i),
        .observed_o(s_observed_o), .covered_o(s_covered_o), .mismatch_cnt_o(s_mismatch_cnt_o),
        .inconsistent_o(s_inconsistent_o), .busy_o(s_busy_o), .done_o(s_done_o), .pass_o(s_pass_o)
`ifdef TT_CHECKER_FIRST_FAIL_EN
        , .first_fail_vld_o(s_first_fail_vld_o), .first_fail_vec_o(s_first_fail_vec_o)
`endif
    );

    // ---------------- reference model (spec-level) ----------------
    typedef struct {
        int         cyc;
        logic [7:0] obs;
        logic [7:0] cov;
        int         cnt;
        bit         incons;
        bit         busy;
        bit         done;
        bit         pass;
        bit         ffv;
        int         ffvec;
    } snap_t;

    bit  m_seen [8];
    bit  m_obs  [8];
    int  m_cnt;
    bit  m_incons;
    bit  m_running;   // a run is in progress
    bit  m_complete;  // the run has seen every vector
    bit  m_ffv;
    int  m_ffvec;

    snap_t exp_q [$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit exp_bit(input int v);
        logic [7:0] t;
        t = EXP_TT;
        return t[v];
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 8; i++) begin
            m_seen[i] = 1'b0;
            m_obs[i]  = 1'b0;
        end
        m_cnt = 0; m_incons = 1'b0; m_ffv = 1'b0; m_ffvec = 0;
    endfunction

    function automatic void model_apply(input bit s, input bit v, input int vec, input bit z);
        int n_seen;
        if (s) begin
            model_clear();
            m_running  = 1'b1;
            m_complete = 1'b0;
        end else if (v && m_running && !m_complete) begin
            if (!m_seen[vec]) begin
                m_seen[vec] = 1'b1;
                m_obs[vec]  = z;
            end else if (m_obs[vec] != z) begin
                m_incons = 1'b1;
            end
            if (z != exp_bit(vec)) begin
                m_cnt++;
                if (!m_ffv) begin m_ffv = 1'b1; m_ffvec = vec; end
            end
            n_seen = 0;
            for (int i = 0; i < 8; i++) n_seen += int'(m_seen[i]);
            if (n_seen == 8) m_complete = 1'b1;
        end
    endfunction

    function automatic snap_t model_snap(input int at_cyc);
        snap_t s;
        s.cyc = at_cyc;
        s.obs = '0;
        s.cov = '0;
        for (int i = 0; i < 8; i++) begin
            s.cov[i] = m_seen[i];
            s.obs[i] = m_seen[i] & m_obs[i];
        end
        s.cnt    = m_cnt;
        s.incons = m_incons;
        s.busy   = m_running && !m_complete;
        s.done   = m_running && m_complete;
        s.pass   = s.done && (m_cnt == 0) && !m_incons;
        s.ffv    = m_ffv;
        s.ffvec  = m_ffvec;
        return s;
    endfunction

    // ---------------- stimulus ----------------
    task automatic step(input bit s, input bit v, input int vec, input bit z);
        @(posedge clk);
        #1;
        start_i = s; valid_i = v; vec_i = 3'(vec); z_i = z;
        model_apply(s, v, vec, z);
        exp_q.push_back(model_snap(cyc + 1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0);
    endtask

    // Asserts rst mid-cycle: outputs must clear before the next edge.
    task automatic do_reset();
        snap_t s;
        @(posedge clk);
        #1;
        rst = 1'b1; start_i = 1'b0; valid_i = 1'b0;
        model_clear();
        m_running = 1'b0; m_complete = 1'b0;
        s = model_snap(cyc);
        if (exp_q.size() > 0 && exp_q[$].cyc == cyc) exp_q[$] = s;
        else exp_q.push_back(s);
        s.cyc = cyc + 1;
        exp_q.push_back(s);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back(model_snap(cyc + 1));
    endtask

    task automatic sweep(input int flip_vec);
        step(1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, i, exp_bit(i) ^ (i == flip_vec));
        idle(2);
    endtask

    // ---------------- monitor ----------------
    task automatic chk(input string nm, input int got, input int want, input int at);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, at, got, want);
    endtask

    initial begin
        snap_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                chk("observed",     int'(observed_o & covered_o), int'(e.obs),  cyc);
                chk("covered",      int'(covered_o),              int'(e.cov),  cyc);
                chk("mismatch_cnt", int'(mismatch_cnt_o),         (e.cnt > 255) ? 255 : e.cnt, cyc);
                chk("inconsistent", int'(inconsistent_o),         int'(e.incons), cyc);
                chk("busy",         int'(busy_o),                 int'(e.busy), cyc);
                chk("done",         int'(done_o),                 int'(e.done), cyc);
                chk("pass",         int'(pass_o),                 int'(e.pass), cyc);
                chk("sat_cnt",      int'(s_mismatch_cnt_o),       (e.cnt > 3) ? 3 : e.cnt, cyc);
`ifdef TT_CHECKER_FIRST_FAIL_EN
                chk("ff_vld",       int'(first_fail_vld_o),       int'(e.ffv),  cyc);
                chk("ff_vec",       int'(first_fail_vec_o),       e.ffvec,      cyc);
`endif
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        snap_t s;
        model_clear();
        m_running = 1'b0; m_complete = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(model_snap(cyc));   // state while rst is held
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back(model_snap(cyc + 1));

        idle(2);
        step(1'b0, 1'b1, 2, 1'b1);          // sample in IDLE ignored
        sweep(-1);                          // clean pass
        step(1'b0, 1'b1, 1, 1'b1);          // sample in DONE ignored
        sweep(5);                           // single mismatch at vec 5

        // 0..6, repeat 3 with a different Z, then 7
        step(1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, i, exp_bit(i));
        step(1'b0, 1'b1, 3, !exp_bit(3));
        idle(1);
        step(1'b0, 1'b1, 7, exp_bit(7));
        idle(1);

        // start and valid together: sample dropped
        step(1'b1, 1'b1, 0, 1'b1);
        idle(1);

        // reset after 4 samples, then samples ignored until start
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, i, exp_bit(i));
        do_reset();
        step(1'b0, 1'b1, 4, 1'b1);
        step(1'b0, 1'b1, 5, 1'b0);
        step(1'b1, 1'b0, 0, 1'b0);

        // five mismatches: CW=2 instance saturates at 3
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, i, !exp_bit(i));
        idle(1);

        // randomized runs
        for (int n = 0; n < 1500; n++) begin
            int r, v;
            bit z;
            r = $urandom_range(0, 99);
            v = $urandom_range(0, 7);
            z = exp_bit(v);
            if ($urandom_range(0, 15) == 0) z = !z;
            if (r < 2) step(1'b1, $urandom_range(0, 1) == 1, v, z);
            else if (r < 3) do_reset();
            else if (r < 80) step(1'b0, 1'b1, v, z);
            else step(1'b0, 1'b0, v, z);
        end
        idle(2);

        repeat (5) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
